// File: rtl/tree_stream_loader_pkg.sv
// Shared types for the tree stream loader: token tags, error codes,
// controller states and the node-record width helper.
package tree_stream_loader_pkg;

  typedef enum logic [1:0] {
    TAG_EMPTY = 2'd0,
    TAG_LEAF  = 2'd1,
    TAG_NODE  = 2'd2,
    TAG_RSVD  = 2'd3
  } tag_e;

  typedef enum logic [1:0] {
    ERR_NONE      = 2'd0,
    ERR_OVERFLOW  = 2'd1,
    ERR_UNDERFLOW = 2'd2,
    ERR_TAG       = 2'd3
  } err_e;

  typedef enum logic [2:0] {
    ST_LOAD   = 3'd0,
    ST_ALLOC  = 3'd1,
    ST_LAUNCH = 3'd2,
    ST_RUN    = 3'd3,
    ST_OUTPUT = 3'd4,
    ST_ERROR  = 3'd5
  } state_e;

  // Token as seen on s_tdata: payload above a 2-bit tag.
  typedef struct packed {
    logic [31:0] payload;
    tag_e        tag;
  } token_t;

  // Node record header; the body width depends on module parameters.
  typedef struct packed {
    tag_e tag;
  } node_hdr_t;

  // Node record = tag + body wide enough for a leaf payload or ARITY pointers.
  function automatic int node_w(input int data_w, input int arity, input int ptr_w);
    return 2 + ((data_w > arity * ptr_w) ? data_w : arity * ptr_w);
  endfunction

endpackage

// File: rtl/tree_stream_loader_ptr_stack.sv
// Pointer stack: single push, pop of a whole ARITY-wide window, and a
// combinational view of the top WIN entries (oldest at index 0).
module tree_stream_loader_ptr_stack #(
  parameter int DEPTH = 256,
  parameter int PTR_W = 16,
  parameter int WIN   = 4,
  localparam int AW   = $clog2(DEPTH),
  localparam int SPW  = AW + 1
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      clr_i,
  input  logic                      push_i,
  input  logic [PTR_W-1:0]          push_data_i,
  input  logic                      popn_i,
  output logic [WIN-1:0][PTR_W-1:0] win_o,
  output logic [SPW-1:0]            sp_o,
  output logic                      full_o,
  output logic                      empty_o
);

  logic [PTR_W-1:0] mem_q [DEPTH];
  logic [SPW-1:0]   sp_q, sp_d;

  // Stack pointer next state; a batch clear wins over push/pop.
  always_comb begin
    sp_d = sp_q;
    if (clr_i)                 sp_d = '0;
    else if (push_i && !full_o) sp_d = sp_q + SPW'(1);
    else if (popn_i)           sp_d = sp_q - SPW'(WIN);
  end

  // Stack pointer register.
  always_ff @(posedge clk) begin
    if (reset) sp_q <= '0;
    else       sp_q <= sp_d;
  end

  // Storage writes; contents need no reset since sp gates all reads.
  always_ff @(posedge clk) begin
    if (push_i && !full_o) mem_q[sp_q[AW-1:0]] <= push_data_i;
  end

  for (genvar k = 0; k < WIN; k++) begin : g_win
    assign win_o[k] = mem_q[AW'(sp_q - SPW'(WIN) + SPW'(k))];
  end

  assign sp_o    = sp_q;
  assign full_o  = (sp_q == SPW'(DEPTH));
  assign empty_o = (sp_q == '0);

endmodule

// File: rtl/tree_stream_loader.sv
// Tree stream loader: turns a post-order token stream into heap node records,
// collects NUM_TREES root pointers, launches the core and returns its result.
module tree_stream_loader
  import tree_stream_loader_pkg::*;
#(
  parameter int NUM_TREES   = 2,
  parameter int ARITY       = 4,
  parameter int STACK_DEPTH = 256,
  parameter int PTR_W       = 16,
  parameter int DATA_W      = 32,
  localparam int NODE_W     = node_w(DATA_W, ARITY, PTR_W)
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [DATA_W+1:0]          s_tdata,
  input  logic                       s_tlast,
  input  logic                       s_tvalid,
  output logic                       s_tready,
  output logic                       alloc_valid,
  input  logic                       alloc_ready,
  output logic [NODE_W-1:0]          alloc_data,
  input  logic                       ptr_valid,
  input  logic [PTR_W-1:0]           ptr_data,
  output logic                       go_valid,
  input  logic                       go_ready,
  output logic [NUM_TREES-1:0]       root_valid,
  input  logic [NUM_TREES-1:0]       root_ready,
  output logic [NUM_TREES*PTR_W-1:0] root_ptr,
  input  logic                       core_valid,
  output logic                       core_ready,
  input  logic [DATA_W-1:0]          core_data,
  output logic                       res_valid,
  input  logic                       res_ready,
  output logic [DATA_W-1:0]          res_data,
  output logic [1:0]                 err
);

  localparam int BODY_W = NODE_W - 2;
  localparam int SPW    = $clog2(STACK_DEPTH) + 1;
  localparam int TIW    = $clog2(NUM_TREES + 1);

  state_e                          state_q;
  logic                            s_tready_q, alloc_valid_q, go_valid_q;
  logic                            core_ready_q, res_valid_q, tlast_q;
  logic [NUM_TREES-1:0]            root_valid_q;
  logic [NUM_TREES-1:0][PTR_W-1:0] root_ptr_q;
  logic [NODE_W-1:0]               alloc_data_q;
  logic [DATA_W-1:0]               res_data_q;
  err_e                            err_q;
  logic [TIW-1:0]                  tree_idx_q;

  logic [ARITY-1:0][PTR_W-1:0] win;
  logic [SPW-1:0]              sp;
  logic                        full, empty, push, popn, clr;

  tag_e              tok_tag;
  logic [DATA_W-1:0] tok_payload;
  logic              accept;
  err_e              tok_err;
  logic [BODY_W-1:0] body;
  logic              go_n;
  logic [NUM_TREES-1:0] root_n;

  assign tok_tag     = tag_e'(s_tdata[1:0]);
  assign tok_payload = s_tdata[DATA_W+1:2];
  assign accept      = (state_q == ST_LOAD) && s_tvalid && s_tready_q;

  // Token legality and node body; a NODE with tlast must leave exactly one
  // entry after its own push, i.e. it must consume the whole stack.
  always_comb begin
    tok_err = ERR_NONE;
    if (tok_tag == TAG_RSVD)                          tok_err = ERR_TAG;
    else if (tok_tag == TAG_NODE && sp < SPW'(ARITY)) tok_err = ERR_UNDERFLOW;
    else if (tok_tag != TAG_NODE && full)             tok_err = ERR_OVERFLOW;
    else if (s_tlast && ((tok_tag == TAG_NODE) ? (sp != SPW'(ARITY)) : !empty))
      tok_err = ERR_UNDERFLOW;
    body = '0;
    if (tok_tag == TAG_LEAF) body[DATA_W-1:0] = tok_payload;
    if (tok_tag == TAG_NODE) begin
      for (int k = 0; k < ARITY; k++) body[k*PTR_W +: PTR_W] = win[k];
    end
  end

  // A root's pointer would be pushed then popped straight back, so tlast
  // pointers bypass the stack and go directly to the root slot.
  assign popn   = accept && (tok_tag == TAG_NODE) && (tok_err == ERR_NONE);
  assign push   = (state_q == ST_ALLOC) && ptr_valid && !tlast_q;
  assign clr    = (state_q == ST_OUTPUT) && res_valid_q && res_ready;
  assign go_n   = go_valid_q && !go_ready;
  assign root_n = root_valid_q & ~root_ready;

  tree_stream_loader_ptr_stack #(
    .DEPTH(STACK_DEPTH), .PTR_W(PTR_W), .WIN(ARITY)
  ) u_ptr_stack (
    .clk(clk), .reset(reset), .clr_i(clr),
    .push_i(push), .push_data_i(ptr_data), .popn_i(popn),
    .win_o(win), .sp_o(sp), .full_o(full), .empty_o(empty)
  );

  // Controller FSM with all handshake outputs registered.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= ST_LOAD;
      s_tready_q    <= 1'b0;
      alloc_valid_q <= 1'b0;
      go_valid_q    <= 1'b0;
      root_valid_q  <= '0;
      core_ready_q  <= 1'b0;
      res_valid_q   <= 1'b0;
      tlast_q       <= 1'b0;
      root_ptr_q    <= '0;
      alloc_data_q  <= '0;
      res_data_q    <= '0;
      err_q         <= ERR_NONE;
      tree_idx_q    <= '0;
    end else begin
      case (state_q)
        ST_LOAD: begin
          s_tready_q <= 1'b1;
          if (accept) begin
            if (tok_err != ERR_NONE) begin
              err_q   <= tok_err;
              state_q <= ST_ERROR;
            end else begin
              alloc_data_q  <= {tok_tag, body};
              alloc_valid_q <= 1'b1;
              tlast_q       <= s_tlast;
              s_tready_q    <= 1'b0;
              state_q       <= ST_ALLOC;
            end
          end
        end
        ST_ALLOC: begin
          if (alloc_ready) alloc_valid_q <= 1'b0;
          if (ptr_valid) begin
            alloc_valid_q <= 1'b0;
            if (tlast_q) begin
              for (int i = 0; i < NUM_TREES; i++)
                if (tree_idx_q == TIW'(i)) root_ptr_q[i] <= ptr_data;
              tree_idx_q <= tree_idx_q + TIW'(1);
            end
            if (tlast_q && tree_idx_q == TIW'(NUM_TREES - 1)) begin
              go_valid_q   <= 1'b1;
              root_valid_q <= '1;
              state_q      <= ST_LAUNCH;
            end else begin
              s_tready_q <= 1'b1;
              state_q    <= ST_LOAD;
            end
          end
        end
        ST_LAUNCH: begin
          go_valid_q   <= go_n;
          root_valid_q <= root_n;
          if (!go_n && root_n == '0) begin
            core_ready_q <= 1'b1;
            state_q      <= ST_RUN;
          end
        end
        ST_RUN: begin
          if (core_valid) begin
            res_data_q   <= core_data;
            res_valid_q  <= 1'b1;
            core_ready_q <= 1'b0;
            state_q      <= ST_OUTPUT;
          end
        end
        ST_OUTPUT: begin
          if (res_ready) begin
            res_valid_q <= 1'b0;
            tree_idx_q  <= '0;
            s_tready_q  <= 1'b1;
            state_q     <= ST_LOAD;
          end
        end
        ST_ERROR: s_tready_q <= 1'b1;
        default:  state_q <= ST_LOAD;
      endcase
    end
  end

  assign s_tready    = s_tready_q;
  assign alloc_valid = alloc_valid_q;
  assign alloc_data  = alloc_data_q;
  assign go_valid    = go_valid_q;
  assign root_valid  = root_valid_q;
  assign root_ptr    = root_ptr_q;
  assign core_ready  = core_ready_q;
  assign res_valid   = res_valid_q;
  assign res_data    = res_data_q;
  assign err         = err_q;

endmodule
